// File: rtl/dfr_pkg.sv
// Shared constants and helpers for the delay-feedback-reservoir readout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dfr_pkg;

    // Default number of fractional bits in weights and readout result.
    localparam int FRAC_BITS_DEF = 16;

    // Working width for the saturation helper; must cover the accumulator.
    localparam int SAT_W = 128;

    // Index width; a single-node reservoir still needs a 1-bit index.
    function automatic int addr_width(input int nodes);
        return (nodes > 1) ? $clog2(nodes) : 1;
    endfunction

    // Accumulator width: full product plus growth headroom for one frame.
    function automatic int acc_width(input int data_w, input int nodes);
        return 2 * data_w + addr_width(nodes);
    endfunction

    // Clip a signed value to the range of a signed 'width'-bit number.
    function automatic logic signed [SAT_W-1:0] sat_clip(
        input logic signed [SAT_W-1:0] v,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = SAT_W'(1) <<< (width - 1);
        hi = hi - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dfr_readout_if.sv
// Sample, weight-write and result signals of the reservoir readout.
// Latency: n/a (wiring only).
// Backpressure: none; samples are accepted whenever din_valid is high.
interface dfr_readout_if
    import dfr_pkg::*;
#(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32
);
    localparam int AW = addr_width(VIRTUAL_NODES);

    logic                         din_valid;
    logic signed [DATA_WIDTH-1:0] din;
    logic                         clear;
    logic                         w_we;
    logic [AW-1:0]                w_addr;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic                         dout_valid;
    logic signed [DATA_WIDTH-1:0] dout;
    logic [AW-1:0]                node_idx;

    // Stimulus side: drives samples and weight writes, observes results.
    modport master (
        output din_valid, din, clear, w_we, w_addr, w_data,
        input  dout_valid, dout, node_idx
    );

    // Readout side.
    modport slave (
        input  din_valid, din, clear, w_we, w_addr, w_data,
        output dout_valid, dout, node_idx
    );
endinterface

// File: rtl/dfr_weight_ram.sv
// Per-node readout weight storage: sync write, async read, cleared on reset.
// Latency: write visible on the cycle after w_we; read is combinational.
// Backpressure: none; out-of-range write addresses are silently dropped.
module dfr_weight_ram
    import dfr_pkg::*;
#(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int AW            = addr_width(VIRTUAL_NODES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);
    localparam logic [AW:0] NODES = (AW+1)'(VIRTUAL_NODES);

    logic signed [DATA_WIDTH-1:0] mem [VIRTUAL_NODES];
    logic                         in_range;

    assign in_range = ({1'b0, waddr} < NODES);

    // Read is asynchronous so a same-cycle write still returns the old weight.
    assign rdata = mem[raddr];

    // Weight update; reset zeroes every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VIRTUAL_NODES; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/dfr_readout.sv
// Linear readout y = sum(w[n]*x[n]) >>> FRAC_BITS over one reservoir frame; READOUT_SAT_EN selects saturation instead of wrap.
// Latency: dout_valid pulses 2 cycles after the last node sample is presented.
// Backpressure: none; every din_valid sample is consumed, gaps allowed, clear drops the frame.
module dfr_readout
    import dfr_pkg::*;
#(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_BITS     = FRAC_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    dfr_readout_if.slave bus
);
    localparam int AW    = addr_width(VIRTUAL_NODES);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, VIRTUAL_NODES);
    localparam logic [AW-1:0] LAST_IDX = AW'(VIRTUAL_NODES - 1);

    logic signed [DATA_WIDTH-1:0] w_rd;
    logic signed [PW-1:0]         din_x;
    logic signed [PW-1:0]         w_x;

    // Stage 1 registers
    logic                         p_vld;
    logic                         p_first;
    logic                         p_last;
    logic signed [PW-1:0]         prod;

    // Stage 2 datapath
    logic signed [ACC_W-1:0]      prod_x;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_sum;
    logic signed [DATA_WIDTH-1:0] y;

    dfr_weight_ram #(
        .VIRTUAL_NODES (VIRTUAL_NODES),
        .DATA_WIDTH    (DATA_WIDTH),
        .AW            (AW)
    ) u_wram (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.w_we),
        .waddr (bus.w_addr),
        .wdata (bus.w_data),
        .raddr (bus.node_idx),
        .rdata (w_rd)
    );

    assign din_x  = {{DATA_WIDTH{bus.din[DATA_WIDTH-1]}}, bus.din};
    assign w_x    = {{DATA_WIDTH{w_rd[DATA_WIDTH-1]}}, w_rd};
    assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};

    // A first-node product starts a fresh sum regardless of leftover accumulator state.
    assign acc_sum = (p_first ? '0 : acc) + prod_x;

    // Scale back to DATA_WIDTH: clip to range, or keep the low bits (two's-complement wrap).
    always_comb begin
        y = '0;
`ifdef READOUT_SAT_EN
        y = DATA_WIDTH'(sat_clip(SAT_W'(acc_sum >>> FRAC_BITS), DATA_WIDTH));
`else
        y = DATA_WIDTH'(acc_sum >>> FRAC_BITS);
`endif
    end

    // Stage 1: accept a sample, multiply by its node weight, advance the node index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.node_idx <= '0;
            p_vld        <= 1'b0;
            p_first      <= 1'b0;
            p_last       <= 1'b0;
            prod         <= '0;
        end else if (bus.clear) begin
            bus.node_idx <= '0;
            p_vld        <= 1'b0;
            p_first      <= 1'b0;
            p_last       <= 1'b0;
        end else begin
            p_vld <= bus.din_valid;
            if (bus.din_valid) begin
                prod         <= din_x * w_x;
                p_first      <= (bus.node_idx == '0);
                p_last       <= (bus.node_idx == LAST_IDX);
                bus.node_idx <= (bus.node_idx == LAST_IDX) ? '0 : bus.node_idx + 1'b1;
            end
        end
    end

    // Stage 2: accumulate products; on the last node publish the scaled sum for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            if (bus.clear) begin
                acc <= '0;
            end else if (p_vld) begin
                if (p_last) begin
                    acc            <= '0;
                    bus.dout       <= y;
                    bus.dout_valid <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end
endmodule
